// File: rtl/tdc_event_buffer_if.sv
// Event stream bundle: TDC codes in, buffered codes out to the histogram builder.
// Handshake: an input code is offered while tdcValid=1; an output code is delivered in each cycle with wrEn=1, and the buffer only pops when rdy=1.
interface tdc_event_buffer_if #(
    parameter int NP = 10
) ();
    logic          tdcValid;
    logic [NP-1:0] tdcCode;
    logic          rdy;
    logic [NP-1:0] roughData;
    logic          wrEn;

    modport master (
        input  tdcValid,
        input  tdcCode,
        input  rdy,
        output roughData,
        output wrEn
    );

    modport slave (
        output tdcValid,
        output tdcCode,
        output rdy,
        input  roughData,
        input  wrEn
    );
endinterface

// File: rtl/tdc_event_buffer.sv
// Gated TDC event FIFO between the TDC and the histogram builder. It is sequenced by
// acquisition and laser-cycle pulses. fsm_state exposes the controller state for debug.
module tdc_event_buffer #(
    parameter int NP     = 10,
    parameter int DEPTH  = 8,
    parameter int CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   res,
    input  logic                   acqStart,
    input  logic                   laserSync,
    input  logic [NP-1:0]          gateMin,
    input  logic [NP-1:0]          gateMax,
    output logic [15:0]            cycleCount,
    output logic [15:0]            dropCount,
    output logic                   busy,
    output logic                   acqDone,
    output logic [2:0]             fsm_state,
    tdc_event_buffer_if.master     bus
);

    localparam int          AW    = $clog2(DEPTH);
    localparam logic [15:0] CYC_L = 16'(CYCLES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_ACQ   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state, state_next;

    logic [NP-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          full, empty;
    logic          in_gate, term_sync, push_window, cand, push, drop, pop;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign in_gate   = (bus.tdcCode >= gateMin) && (bus.tdcCode <= gateMax);
    assign term_sync = (state == S_ACQ) && laserSync && (cycleCount == CYC_L);

    // The laserSync that opens the acquisition also opens the window; the one that closes it does not.
    assign push_window = ((state == S_ACQ) && !term_sync) || ((state == S_ARM) && laserSync);
    assign cand        = push_window && bus.tdcValid && in_gate;
    assign push        = cand && !full;
    assign drop        = cand && full;
    assign pop         = ((state == S_ACQ) || (state == S_DRAIN)) && !empty && bus.rdy;

    always_ff @(posedge clk) begin
        if (res) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (acqStart)  state_next = S_ARM;
            S_ARM:   if (laserSync) state_next = S_ACQ;
            S_ACQ:   if (term_sync) state_next = S_DRAIN;
            S_DRAIN: if (empty)     state_next = S_DONE;
            S_DONE:                 state_next = S_IDLE;
            default:                state_next = S_IDLE;
        endcase
    end

    assign busy      = (state == S_ACQ) || (state == S_DRAIN);
    assign acqDone   = (state == S_DONE);
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= bus.tdcCode;
    end

    always_ff @(posedge clk) begin
        if (res) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            bus.wrEn      <= 1'b0;
            bus.roughData <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            bus.wrEn <= pop;
            if (pop) bus.roughData <= mem[rd_ptr[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            cycleCount <= '0;
        end else if ((state == S_IDLE) && acqStart) begin
            cycleCount <= '0;
        end else if ((state == S_ARM) && laserSync) begin
            cycleCount <= 16'd1;
        end else if ((state == S_ACQ) && laserSync && (cycleCount < CYC_L)) begin
            cycleCount <= cycleCount + 16'd1;
        end
    end

    // A full FIFO drops even when a pop frees a slot in the same cycle.
    always_ff @(posedge clk) begin
        if (res) begin
            dropCount <= '0;
        end else if ((state == S_IDLE) && acqStart) begin
            dropCount <= '0;
        end else if (drop && (dropCount != 16'hFFFF)) begin
            dropCount <= dropCount + 16'd1;
        end
    end

endmodule
